// File: rtl/bp_update_scheduler_if.sv
// Update-port bundle between the branch-resolution requesters, the scheduler and the predictor.
interface bp_update_scheduler_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    logic                     ex_valid;
    logic [31:0]              ex_pc;
    logic                     ex_taken;
    logic                     ex_mispred;
    logic                     ex_ready;
    logic                     cm_valid;
    logic [31:0]              cm_pc;
    logic                     cm_taken;
    logic                     cm_ready;
    logic                     flush;
    logic                     upd_hold;
    logic                     upd_valid;
    logic [31:0]              upd_pc;
    logic                     upd_taken;
    logic [$clog2(DEPTH):0]   q_count;
    logic [CNT_W-1:0]         mispred_cnt;

    modport master (
        output ex_valid, ex_pc, ex_taken, ex_mispred,
        output cm_valid, cm_pc, cm_taken,
        output flush, upd_hold,
        input  ex_ready, cm_ready, upd_valid, upd_pc, upd_taken, q_count, mispred_cnt
    );

    modport slave (
        input  ex_valid, ex_pc, ex_taken, ex_mispred,
        input  cm_valid, cm_pc, cm_taken,
        input  flush, upd_hold,
        output ex_ready, cm_ready, upd_valid, upd_pc, upd_taken, q_count, mispred_cnt
    );
endinterface

// File: rtl/bp_update_scheduler.sv
// Arbitrates execute/commit branch-training updates into a FIFO that drains one
// update per cycle into the tournament predictor's single update port.
module bp_update_scheduler #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    bp_update_scheduler_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_QW = PTR_W + 1;
    localparam logic [CNT_QW-1:0] FULL_CNT = CNT_QW'(DEPTH);
    localparam logic [CNT_W-1:0]  SAT_CNT  = {CNT_W{1'b1}};

    logic [32:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_QW-1:0]  count_r;
    logic               rr_r;
    logic [CNT_W-1:0]   mispred_cnt_r;

    logic               full_s;
    logic               empty_s;
    logic               grant_ex_s;
    logic               grant_cm_s;
    logic               push_s;
    logic               pop_s;
    logic [32:0]        wr_data_s;
    logic [32:0]        head_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {CNT_QW{1'b0}});
    assign push_s  = grant_ex_s | grant_cm_s;
    assign head_s  = mem_r[rd_ptr_r];

    // Grant selection: mispredict beats round-robin; fullness is the pre-pop value.
    always_comb begin
        grant_ex_s = 1'b0;
        grant_cm_s = 1'b0;
        if (!rst_n || full_s || bus.flush) begin
            grant_ex_s = 1'b0;
            grant_cm_s = 1'b0;
        end else if (bus.ex_valid && bus.ex_mispred) begin
            grant_ex_s = 1'b1;
        end else if (bus.ex_valid && bus.cm_valid) begin
            if (rr_r) begin
                grant_cm_s = 1'b1;
            end else begin
                grant_ex_s = 1'b1;
            end
        end else if (bus.ex_valid) begin
            grant_ex_s = 1'b1;
        end else if (bus.cm_valid) begin
            grant_cm_s = 1'b1;
        end else begin
            grant_ex_s = 1'b0;
            grant_cm_s = 1'b0;
        end
    end

    // Write-data mux and drain condition.
    always_comb begin
        wr_data_s = 33'h0;
        if (grant_ex_s) begin
            wr_data_s = {bus.ex_pc, bus.ex_taken};
        end else begin
            wr_data_s = {bus.cm_pc, bus.cm_taken};
        end
        pop_s = rst_n && !empty_s && !bus.upd_hold && !bus.flush;
    end

    assign bus.ex_ready    = grant_ex_s;
    assign bus.cm_ready    = grant_cm_s;
    assign bus.upd_valid   = pop_s;
    assign bus.upd_pc      = pop_s ? head_s[32:1] : 32'h0;
    assign bus.upd_taken   = pop_s ? head_s[0] : 1'b0;
    assign bus.q_count     = count_r;
    assign bus.mispred_cnt = mispred_cnt_r;

    // FIFO storage, pointers and occupancy; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 33'h0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_QW{1'b0}};
        end else if (bus.flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_QW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_QW'(1'b1);
                2'b01:   count_r <= count_r - CNT_QW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Round-robin pointer and saturating mispredict counter; both survive flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r          <= 1'b0;
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (grant_ex_s) begin
                rr_r <= 1'b1;
            end else if (grant_cm_s) begin
                rr_r <= 1'b0;
            end else begin
                rr_r <= rr_r;
            end
            if (grant_ex_s && bus.ex_mispred && (mispred_cnt_r != SAT_CNT)) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_W'(1'b1);
            end else begin
                mispred_cnt_r <= mispred_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scenario bench for bp_update_scheduler: expected updates queued at grant time,
// compared in acceptance order as the predictor port drains them.
module tb_bp_update_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_update_scheduler_if #(.DEPTH(8), .CNT_W(16)) bus ();

    bp_update_scheduler #(.DEPTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;
    logic        rr_m = 1'b0;
    logic [15:0] mis_m = 16'h0;
    logic        exp_ex;

    // Scoreboard drain side: every predictor update must match the oldest accepted request.
    always @(negedge clk) begin
        if (rst_n && bus.upd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected got pc=%h taken=%b required no update", bus.upd_pc, bus.upd_taken);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.upd_pc, bus.upd_taken} !== mon_e) begin
                    errors++;
                    $display("FAIL drain_order got pc=%h taken=%b required pc=%h taken=%b",
                             bus.upd_pc, bus.upd_taken, mon_e[32:1], mon_e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.ex_valid   = 1'b0;
        bus.ex_pc      = 32'h0;
        bus.ex_taken   = 1'b0;
        bus.ex_mispred = 1'b0;
        bus.cm_valid   = 1'b0;
        bus.cm_pc      = 32'h0;
        bus.cm_taken   = 1'b0;
        bus.flush      = 1'b0;
        bus.upd_hold   = 1'b0;
    endtask

    task automatic wait_drain();
        bus.upd_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.q_count !== 4'd0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d q_count=%0d required 0 and 0", exp_q.size(), bus.q_count);
        end
    endtask

    task automatic test_reset();
        set_idle();
        bus.ex_valid = 1'b1;
        bus.ex_pc    = 32'h44;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.ex_ready, bus.cm_ready, bus.upd_valid, bus.upd_pc, bus.upd_taken} !== 35'h0 ||
            bus.q_count !== 4'd0 || bus.mispred_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_init got rdy=%b%b v=%b pc=%h q=%0d m=%0d required all zero",
                     bus.ex_ready, bus.cm_ready, bus.upd_valid, bus.upd_pc, bus.q_count, bus.mispred_cnt);
        end
        rst_n = 1'b1;
        set_idle();
        bus.upd_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.ex_valid   = 1'b1;
            bus.ex_mispred = 1'b1;
            bus.ex_pc      = 32'h0000_0A00 + 32'(i * 4);
            bus.ex_taken   = 1'(i);
            @(negedge clk);
            checks++;
            if (bus.ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_fill_ready got %b required 1", bus.ex_ready);
            end
            exp_q.push_back({bus.ex_pc, bus.ex_taken});
            rr_m  = 1'b1;
            mis_m = mis_m + 16'd1;
        end
        tick();
        bus.ex_mispred = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.q_count !== 4'd5 || bus.mispred_cnt !== mis_m) begin
            errors++;
            $display("FAIL reset_prefill got q=%0d m=%0d required q=5 m=%0d", bus.q_count, bus.mispred_cnt, mis_m);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ex_ready, bus.cm_ready, bus.upd_valid, bus.upd_pc, bus.upd_taken} !== 35'h0 ||
            bus.q_count !== 4'd0 || bus.mispred_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_async got rdy=%b v=%b pc=%h q=%0d m=%0d required all zero",
                     bus.ex_ready, bus.upd_valid, bus.upd_pc, bus.q_count, bus.mispred_cnt);
        end
        exp_q.delete();
        rr_m  = 1'b0;
        mis_m = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
    endtask

    task automatic test_single();
        tick();
        bus.ex_valid = 1'b1;
        bus.ex_pc    = 32'h100;
        bus.ex_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ex_ready !== 1'b1 || bus.cm_ready !== 1'b0 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept got ex_rdy=%b cm_rdy=%b v=%b required 1 0 0", bus.ex_ready, bus.cm_ready, bus.upd_valid);
        end
        exp_q.push_back({32'h100, 1'b1});
        rr_m = 1'b1;
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (bus.upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got upd_valid=%b required 1", bus.upd_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after got upd_valid=%b required 0", bus.upd_valid);
        end
    endtask

    task automatic test_round_robin();
        tick();
        bus.cm_valid = 1'b1;
        bus.cm_pc    = 32'h200;
        bus.cm_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cm_ready !== 1'b1 || bus.ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_lone_cm got cm_rdy=%b ex_rdy=%b required 1 0", bus.cm_ready, bus.ex_ready);
        end
        exp_q.push_back({32'h200, 1'b0});
        rr_m = 1'b0;
        tick();
        set_idle();
        wait_drain();
        bus.upd_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.ex_valid = 1'b1;
            bus.ex_pc    = 32'h3000 + 32'(i * 8);
            bus.ex_taken = 1'b1;
            bus.cm_valid = 1'b1;
            bus.cm_pc    = 32'h3004 + 32'(i * 8);
            bus.cm_taken = 1'b0;
            @(negedge clk);
            exp_ex = !rr_m;
            checks++;
            if (bus.ex_ready !== exp_ex || bus.cm_ready !== !exp_ex) begin
                errors++;
                $display("FAIL rr_grant%0d got ex=%b cm=%b required ex=%b cm=%b", i, bus.ex_ready, bus.cm_ready, exp_ex, !exp_ex);
            end
            exp_q.push_back(exp_ex ? {bus.ex_pc, bus.ex_taken} : {bus.cm_pc, bus.cm_taken});
            rr_m = exp_ex;
        end
        tick();
        bus.ex_valid = 1'b0;
        bus.cm_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.q_count !== 4'd4 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_hold got q=%0d v=%b required q=4 v=0", bus.q_count, bus.upd_valid);
        end
        wait_drain();
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.ex_valid   = 1'b1;
            bus.ex_mispred = 1'b1;
            bus.ex_pc      = 32'h4000 + 32'(i * 4);
            bus.ex_taken   = 1'b0;
            bus.cm_valid   = 1'b1;
            bus.cm_pc      = 32'h4800 + 32'(i * 4);
            @(negedge clk);
            checks++;
            if (bus.ex_ready !== 1'b1 || bus.cm_ready !== 1'b0) begin
                errors++;
                $display("FAIL prio_grant%0d got ex=%b cm=%b required ex=1 cm=0", i, bus.ex_ready, bus.cm_ready);
            end
            exp_q.push_back({bus.ex_pc, 1'b0});
            rr_m  = 1'b1;
            mis_m = mis_m + 16'd1;
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (bus.mispred_cnt !== mis_m) begin
            errors++;
            $display("FAIL prio_mispred_cnt got %0d required %0d", bus.mispred_cnt, mis_m);
        end
        wait_drain();
    endtask

    task automatic test_full_wrap();
        bus.upd_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.ex_valid = 1'b1;
            bus.ex_pc    = 32'h5000 + 32'(i * 4);
            bus.ex_taken = 1'(i);
            @(negedge clk);
            checks++;
            if (bus.ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d got ex_rdy=%b required 1", i, bus.ex_ready);
            end
            exp_q.push_back({bus.ex_pc, bus.ex_taken});
            rr_m = 1'b1;
        end
        tick();
        bus.ex_pc = 32'h5100;
        @(negedge clk);
        checks++;
        if (bus.q_count !== 4'd8 || bus.ex_ready !== 1'b0 || bus.cm_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse got q=%0d ex_rdy=%b required q=8 ex_rdy=0", bus.q_count, bus.ex_ready);
        end
        tick();
        bus.upd_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ex_ready !== 1'b0 || bus.upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_prepop got ex_rdy=%b v=%b required ex_rdy=0 v=1", bus.ex_ready, bus.upd_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.ex_pc    = 32'h5200 + 32'(i * 4);
            bus.ex_taken = 1'(~i);
            @(negedge clk);
            checks++;
            if (bus.ex_ready !== 1'b1 || bus.q_count !== 4'd7) begin
                errors++;
                $display("FAIL wrap_push%0d got ex_rdy=%b q=%0d required ex_rdy=1 q=7", i, bus.ex_ready, bus.q_count);
            end
            exp_q.push_back({bus.ex_pc, bus.ex_taken});
        end
        tick();
        set_idle();
        wait_drain();
    endtask

    task automatic test_flush();
        bus.upd_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.cm_valid = 1'b1;
            bus.cm_pc    = 32'h6000 + 32'(i * 4);
            bus.cm_taken = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.cm_ready !== 1'b1 || bus.ex_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_fill%0d got cm_rdy=%b required 1", i, bus.cm_ready);
            end
            exp_q.push_back({bus.cm_pc, 1'b1});
            rr_m = 1'b0;
        end
        tick();
        bus.cm_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.q_count !== 4'd6) begin
            errors++;
            $display("FAIL flush_prefill got q=%0d required 6", bus.q_count);
        end
        bus.flush    = 1'b1;
        bus.ex_valid = 1'b1;
        bus.ex_pc    = 32'h6F00;
        bus.upd_hold = 1'b0;
        #1;
        checks++;
        if (bus.ex_ready !== 1'b0 || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_block got ex_rdy=%b v=%b required 0 0", bus.ex_ready, bus.upd_valid);
        end
        exp_q.delete();
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (bus.q_count !== 4'd0 || bus.mispred_cnt !== mis_m || bus.upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got q=%0d m=%0d v=%b required q=0 m=%0d v=0", bus.q_count, bus.mispred_cnt, bus.upd_valid, mis_m);
        end
        tick();
        bus.ex_valid = 1'b1;
        bus.ex_pc    = 32'h7000;
        bus.cm_valid = 1'b1;
        bus.cm_pc    = 32'h7004;
        @(negedge clk);
        exp_ex = !rr_m;
        checks++;
        if (bus.ex_ready !== exp_ex || bus.cm_ready !== !exp_ex) begin
            errors++;
            $display("FAIL flush_rr_kept got ex=%b cm=%b required ex=%b", bus.ex_ready, bus.cm_ready, exp_ex);
        end
        exp_q.push_back(exp_ex ? {bus.ex_pc, bus.ex_taken} : {bus.cm_pc, bus.cm_taken});
        rr_m = exp_ex;
        tick();
        set_idle();
        wait_drain();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_full_wrap();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
